// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch / program-counter sequencer for the
// single-issue MIPS core. Owns the PC, fetches over a req/ready handshake,
// holds the instruction for the decoder and selects the next PC at commit.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : a jr to a non-word-aligned target sets the sticky misalign
//               flag, leaves pc unchanged and parks the sequencer in HALT
//               until reset.
//   undefined : jr targets are forced word-aligned, misalign is tied 0 and
//               HALT is never entered.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic [1:0]  pc_op,
  input  logic        is_jr,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] OP_SEQ  = 2'b00;
  localparam logic [1:0] OP_BEQ  = 2'b01;
  localparam logic [1:0] OP_BNE  = 2'b10;
  localparam logic [1:0] OP_JUMP = 2'b11;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        misalign_q;

  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] pc_d;
  logic        jr_bad;

  // Branch offset: sign-extended 16-bit word offset, scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Next-PC candidates; all adds wrap modulo 2^32 by construction.
  always_comb begin
    pc4     = pc_q + 32'd4;
    br_tgt  = pc4 + branch_offset(instr_q[15:0]);
    jmp_tgt = {pc4[31:28], instr_q[25:0], 2'b00};
`ifdef PC_ALIGN_CHECK_EN
    jr_tgt  = rs_data;
    jr_bad  = is_jr && (rs_data[1:0] != 2'b00);
`else
    jr_tgt  = {rs_data[31:2], 2'b00};
    jr_bad  = 1'b0;
`endif
  end

`ifndef PC_ALIGN_CHECK_EN
  // The low jr address bits are discarded when alignment is forced.
  logic rs_lsb_unused;
  assign rs_lsb_unused = ^rs_data[1:0];
`endif

  // Next-PC select: jr overrides the decoder's PCOp.
  always_comb begin
    pc_d = pc4;
    if (is_jr) begin
      pc_d = jr_tgt;
    end else begin
      case (pc_op)
        OP_SEQ:  pc_d = pc4;
        OP_BEQ:  pc_d = alu_zero ? br_tgt : pc4;
        OP_BNE:  pc_d = alu_zero ? pc4 : br_tgt;
        OP_JUMP: pc_d = jmp_tgt;
        default: pc_d = pc4;
      endcase
    end
  end

  // Sequencer FSM: owns state, pc, held instruction and sticky misalign.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            if (jr_bad) begin
              misalign_q <= 1'b1;
              state_q    <= S_HALT;
            end else begin
              pc_q    <= pc_d;
              state_q <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only; imem_ready never reaches imem_req.
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_EXEC) && !stall;
  assign pc          = pc_q;
  assign link_addr   = pc4;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// instruction streams compared against a behavioural next-PC model.
module tb_pc_sequencer;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic [1:0]  pc_op;
  logic        is_jr;
  logic        alu_zero;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        misalign;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_pc;
  bit          exp_halt;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .stall      (stall),
    .pc_op      (pc_op),
    .is_jr      (is_jr),
    .alu_zero   (alu_zero),
    .rs_data    (rs_data),
    .pc         (pc),
    .link_addr  (link_addr),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural next-PC: plain arithmetic on the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic [1:0] op, input logic jr,
                                             input logic z, input logic [31:0] rs);
    logic [31:0] seq;
    logic [31:0] off;
    int          soff;
    seq  = cur + 32'd4;
    soff = int'($signed(word[15:0])) * 4;
    off  = soff;
    if (jr) return rs & 32'hFFFF_FFFC;
    if (op == 2'd1) return z ? seq + off : seq;
    if (op == 2'd2) return z ? seq : seq + off;
    if (op == 2'd3) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    return seq;
  endfunction

  // One instruction: `waits` memory wait cycles, `stalls` stall cycles, then commit.
  task automatic run_instr(input logic [31:0] word, input logic [1:0] op, input logic jr,
                           input logic z, input logic [31:0] rs, input int waits,
                           input int stalls);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      imem_ready = (i == waits);
      imem_rdata = (i == waits) ? word : $urandom;
      stall      = 1'b0;
      #1;
      total++;
      if (imem_req !== 1'b1) begin
        bad++; $display("FAIL fetch_req: got %b want 1 (pc %h)", imem_req, exp_pc);
      end
      total++;
      if (imem_addr !== exp_pc) begin
        bad++; $display("FAIL fetch_addr: got %h want %h", imem_addr, exp_pc);
      end
    end
    for (int s = 0; s <= stalls; s++) begin
      @(negedge clk);
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      stall      = (s < stalls);
      pc_op      = op;
      is_jr      = jr;
      alu_zero   = z;
      rs_data    = rs;
      #1;
      total++;
      if (imem_req !== 1'b0) begin
        bad++; $display("FAIL exec_req: got %b want 0", imem_req);
      end
      total++;
      if (instr !== word) begin
        bad++; $display("FAIL exec_instr: got %h want %h", instr, word);
      end
      total++;
      if (instr_valid !== !(s < stalls)) begin
        bad++; $display("FAIL exec_valid: got %b want %b", instr_valid, !(s < stalls));
      end
      total++;
      if (pc !== exp_pc) begin
        bad++; $display("FAIL exec_pc: got %h want %h", pc, exp_pc);
      end
      total++;
      if (link_addr !== exp_pc + 32'd4) begin
        bad++; $display("FAIL link_addr: got %h want %h", link_addr, exp_pc + 32'd4);
      end
    end
    if (ALIGN && jr && (rs[1:0] != 2'b00)) exp_halt = 1'b1;
    else exp_pc = model_next(exp_pc, word, op, jr, z, rs);
  endtask

  // Holds reset for two cycles, checks reset values, releases into IDLE.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    imem_ready = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (pc !== RST_PC || imem_addr !== RST_PC || link_addr !== RST_PC + 32'd4) begin
      bad++; $display("FAIL reset_pc: got pc %h addr %h link %h want %h", pc, imem_addr, link_addr, RST_PC);
    end
    total++;
    if (imem_req !== 1'b0 || instr !== 32'h0 || instr_valid !== 1'b0 || misalign !== 1'b0) begin
      bad++; $display("FAIL reset_ctl: got req %b instr %h valid %b mis %b want 0", imem_req, instr, instr_valid, misalign);
    end
    reset = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL idle_req: got %b want 0", imem_req);
    end
    exp_pc   = RST_PC;
    exp_halt = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) run_instr($urandom, 2'd0, 1'b0, $urandom_range(0, 1), $urandom, 0, 0);
    total++;
    if (exp_pc !== 32'h10) begin
      bad++; $display("FAIL seq_model: got %h want 00000010", exp_pc);
    end
  endtask

  task automatic test_branches();
    logic [31:0] w;
    w = 32'h1000_FFFE;
    run_instr($urandom, 2'd0, 1'b1, 1'b0, 32'h40, 0, 0);
    run_instr(w, 2'd1, 1'b0, 1'b1, 32'h0, 0, 0);          // beq taken -> 0x3C
    run_instr($urandom, 2'd0, 1'b1, 1'b0, 32'h40, 0, 0);  // 0x3C jr -> 0x40
    run_instr(w, 2'd1, 1'b0, 1'b0, 32'h0, 0, 0);          // beq not taken -> 0x44
    run_instr($urandom, 2'd0, 1'b1, 1'b0, 32'h40, 0, 0);
    run_instr(w, 2'd2, 1'b0, 1'b0, 32'h0, 0, 0);          // bne taken -> 0x3C
    run_instr($urandom, 2'd0, 1'b1, 1'b0, 32'h40, 0, 0);
    run_instr(w, 2'd2, 1'b0, 1'b1, 32'h0, 0, 0);          // bne not taken -> 0x44
    // next fetch address is checked by the following run_instr
    run_instr($urandom, 2'd0, 1'b0, 1'b0, 32'h0, 0, 0);
    total++;
    if (exp_pc !== 32'h48) begin
      bad++; $display("FAIL branch_chain: got %h want 00000048", exp_pc);
    end
  endtask

  task automatic test_jal_wrap();
    run_instr($urandom, 2'd0, 1'b1, 1'b0, 32'h1000_0010, 0, 0);
    run_instr(32'h0C00_0100, 2'd3, 1'b0, 1'b0, 32'h0, 0, 0);  // link 0x1000_0014
    total++;
    if (exp_pc !== 32'h1000_0400) begin
      bad++; $display("FAIL jal_model: got %h want 10000400", exp_pc);
    end
    run_instr($urandom, 2'd0, 1'b1, 1'b0, 32'hFFFF_FFFC, 0, 0);
    run_instr($urandom, 2'd0, 1'b0, 1'b0, 32'h0, 0, 0);       // wraps to 0
    run_instr($urandom, 2'd0, 1'b0, 1'b0, 32'h0, 0, 0);
  endtask

  task automatic test_wait_stall();
    run_instr($urandom, 2'd0, 1'b1, 1'b0, 32'h0000_0200, 3, 2);
    run_instr($urandom, 2'd0, 1'b0, 1'b0, 32'h0, 0, 0);
  endtask

  task automatic test_misalign();
    run_instr($urandom, 2'd1, 1'b1, 1'b1, 32'h0000_0202, 0, 0);
    if (ALIGN) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        stall = 1'b0;
        imem_ready = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign !== 1'b1 || pc !== exp_pc) begin
          bad++; $display("FAIL halt: got req %b valid %b mis %b pc %h want 0 0 1 %h", imem_req, instr_valid, misalign, pc, exp_pc);
        end
      end
      do_reset();
    end else begin
      total++;
      if (exp_pc !== 32'h200) begin
        bad++; $display("FAIL jr_align_model: got %h want 00000200", exp_pc);
      end
      run_instr($urandom, 2'd0, 1'b0, 1'b0, 32'h0, 0, 0);
      total++;
      if (misalign !== 1'b0) begin
        bad++; $display("FAIL misalign_tied: got %b want 0", misalign);
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    run_instr($urandom, 2'd0, 1'b0, 1'b0, 32'h0, 0, 0);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1) begin
      bad++; $display("FAIL midfetch_req: got %b want 1", imem_req);
    end
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0 || pc !== RST_PC) begin
      bad++; $display("FAIL async_reset: got req %b pc %h want 0 %h", imem_req, pc, RST_PC);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_pc = RST_PC;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle: got %b want 0", imem_req);
    end
    run_instr($urandom, 2'd0, 1'b0, 1'b0, 32'h0, 1, 0);
  endtask

  task automatic test_random();
    logic [31:0] rs;
    logic        jr;
    for (int n = 0; n < 150; n++) begin
      jr = ($urandom_range(0, 7) == 0);
      rs = $urandom;
      if (ALIGN) rs[1:0] = 2'b00;
      run_instr($urandom, 2'($urandom_range(0, 3)), jr, 1'($urandom_range(0, 1)), rs,
                $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    reset = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    stall = 1'b0;
    pc_op = 2'd0;
    is_jr = 1'b0;
    alu_zero = 1'b0;
    rs_data = 32'h0;
    exp_pc = RST_PC;
    exp_halt = 1'b0;
    test_reset();
    test_sequential();
    test_branches();
    test_jal_wrap();
    test_wait_stall();
    test_misalign();
    test_reset_mid_fetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch and program-counter sequencer for the single-issue MIPS core. It owns the PC register, fetches each instruction from instruction memory over a req/ready handshake, and presents the instruction to the main control decoder and datapath. At each commit it consumes the decoder's PCOp, the jr_control jr flag and the ALU zero flag to select the next PC. It also supplies the jal link address.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ready  in  1  memory has accepted the request; imem_rdata is valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  held instruction; opcode = instr[31:26] to control.
- instr_valid  out  1  commit strobe; the datapath writes state only when this is high.
- stall  in  1  holds the current instruction in EXEC without committing.
- pc_op  in  2  PCOp from control: 00 seq, 01 beq, 10 bne, 11 jump.
- is_jr  in  1  jr flag from jr_control; overrides pc_op.
- alu_zero  in  1  ALU zero flag for the current instruction.
- rs_data  in  32  register rs value, used as the jr target.
- pc  out  32  current PC.
- link_addr  out  32  pc+4, combinational; jal writes this value to $ra.
- misalign  out  1  sticky jr-misalignment flag (see Configuration).

## Operation
- States: IDLE, FETCH, EXEC, HALT. Encoding is free.
- IDLE: entered on reset. Unconditionally goes to FETCH on the next edge.
- FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_ready. On the edge where imem_ready=1, instr<=imem_rdata and the FSM goes to EXEC. Ready in the first FETCH cycle is legal.
- EXEC: imem_req=0, and instr_valid equals ~stall.
  - stall=1: remain in EXEC; pc and instr are held.
  - stall=0: commit. pc<=next_pc and the FSM goes to FETCH.
- next_pc, where pc4 = pc+4:
  - If is_jr=1: rs_data, regardless of pc_op.
  - pc_op=00: pc4.
  - pc_op=01: pc4 + (sext(instr[15:0])<<2) if alu_zero=1, else pc4.
  - pc_op=10: the same branch target if alu_zero=0, else pc4.
  - pc_op=11: {pc4[31:28], instr[25:0], 2'b00}.
- All adds are 32-bit modulo 2^32; there is no overflow flag.
  - pc=32'hFFFF_FFFC sequential gives 32'h0000_0000.
  - Negative branch offsets wrap the same way.
- Reset mid-fetch or mid-stall: the request is abandoned and imem_req drops immediately (asynchronous). The memory side must tolerate a dropped request.

## Timing
- Reset values:
  - pc=RESET_PC, link_addr=RESET_PC+4, imem_addr=RESET_PC.
  - imem_req=0, instr=0, instr_valid=0, misalign=0, state IDLE.
- First imem_req is the cycle after reset deasserts (IDLE lasts 1 cycle).
- Minimum instruction period is 2 cycles: 1 FETCH cycle with immediate ready, plus 1 EXEC cycle. Each memory wait cycle adds 1; each stall cycle adds 1.
- instr is stable from the EXEC entry through commit.
- Control outputs derived from instr are valid combinationally within EXEC.
- pc changes only on the commit edge (or on reset). link_addr follows pc combinationally.
- imem_req and imem_addr are registered-state decodes with no combinational path from imem_ready.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - At commit with is_jr=1 and rs_data[1:0]!=2'b00, misalign<=1 (sticky), pc is not updated, and the FSM goes to HALT.
  - HALT: imem_req=0, instr_valid=0. Only reset leaves HALT.
- PC_ALIGN_CHECK_EN undefined:
  - The jr target is {rs_data[31:2], 2'b00}.
  - misalign is tied 0 and HALT is unreachable; it may be optimised out.

## Test plan
- Reset release, imem_ready tied 1, all pc_op=00: imem_addr sequence 0,4,8,... with one instr_valid pulse every 2 cycles; first imem_req is the cycle after reset falls.
- beq at pc=0x40, instr[15:0]=16'hFFFE, alu_zero=1: next fetch at 0x3C. Same with alu_zero=0: next fetch at 0x44. bne with inverse zero: mirror results.
- jal at pc=0x1000_0010, instr[25:0]=26'h000_0100, pc_op=11: link_addr=0x1000_0014 during EXEC; next pc=0x1000_0400.
- jr with rs_data=0x0000_0200 and pc_op=00: next pc=0x200. imem_ready delayed 3 cycles: imem_req and imem_addr hold steady for 4 FETCH cycles. stall=1 for 2 EXEC cycles: instr_valid low, pc held, then one commit.
- jr with rs_data=0x0000_0202: with PC_ALIGN_CHECK_EN, misalign=1 and no further imem_req until reset; without the macro, next pc=0x200 and misalign stays 0.
- Reset asserted while in FETCH with imem_ready=0: imem_req drops the same cycle, pc returns to RESET_PC, and fetch restarts after release.
